// File: rtl/score_frame_rx_pkg.sv
// Shared types and helpers for the inter-board score link receiver.
// Frame: A5, P2, P1, P0, CHK (CHK = P2^P1^P0), score = {P2,P1,P0} in BCD.
package score_frame_rx_pkg;

  localparam logic [7:0] SCORE_HDR = 8'hA5;

  typedef enum logic [2:0] {
    F_HDR,
    F_P2,
    F_P1,
    F_P0,
    F_CHK
  } frame_st_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } byte_st_e;

  function automatic int clks_per_bit(int hz, int baud);
    return hz / baud;
  endfunction

  function automatic logic bcd_ok(logic [23:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/score_frame_rx_if.sv
// Serial line in, decoded score and status out.
// master = link/test side, slave = receiver.
interface score_frame_rx_if;
  logic        rx;
  logic [23:0] points_out;
  logic        points_valid;
  logic        frame_err;
  logic        link_up;

  modport master (
    output rx,
    input  points_out,
    input  points_valid,
    input  frame_err,
    input  link_up
  );

  modport slave (
    input  rx,
    output points_out,
    output points_valid,
    output frame_err,
    output link_up
  );
endinterface

// File: rtl/score_frame_rx_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop rx synchroniser plus byte FSM.
// idle port exists only with SCORE_RX_TIMEOUT_EN defined.
module uart_rx_byte
  import score_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_ok,
`ifdef SCORE_RX_TIMEOUT_EN
  output logic       idle,
`endif
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          meta_q, meta_d;
  logic          rxs_q, rxs_d;
  byte_st_e      st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      st_q   <= IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      meta_q <= meta_d;
      rxs_q  <= rxs_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
    end
  end

  always_comb begin
    meta_d   = rx;
    rxs_d    = meta_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_ok  = 1'b0;
    byte_err = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!rxs_q) begin
          st_d  = START;
          cnt_d = '0;
          bit_d = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          st_d  = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_ok = 1'b1;
            st_d    = IDLE;
          end else begin
            byte_err = 1'b1;
            st_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // a held-low break must not look like a new start bit
      WAIT_HIGH: begin
        if (rxs_q) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign data = sh_q;
`ifdef SCORE_RX_TIMEOUT_EN
  assign idle = (st_q == IDLE);
`endif

endmodule

// File: rtl/score_frame_rx.sv
// Score link receiver: assembles and validates 5-byte score frames.
// Optional inter-byte timeout: define SCORE_RX_TIMEOUT_EN.
module score_frame_rx
  import score_frame_rx_pkg::*;
#(
  parameter int CLK_HZ = 75000000,
  parameter int BAUD   = 115200
`ifdef SCORE_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BITS = 30
`endif
) (
  input logic             pclk,
  input logic             rst,
  score_frame_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0]  bdata;
  logic        byte_ok;
  logic        byte_err;

  frame_st_e   fs_q, fs_d;
  logic [7:0]  p2_q, p2_d, p1_q, p1_d, p0_q, p0_d;
  logic [23:0] pts_q, pts_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        link_q, link_d;
  logic [7:0]  chk;

`ifdef SCORE_RX_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TO_CLKS - 1);
  logic          byte_idle;
  logic          to_hit;
  logic [TW-1:0] to_q, to_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (pclk),
    .rst     (rst),
    .rx      (bus.rx),
    .data    (bdata),
    .byte_ok (byte_ok),
`ifdef SCORE_RX_TIMEOUT_EN
    .idle    (byte_idle),
`endif
    .byte_err(byte_err)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fs_q    <= F_HDR;
      p2_q    <= '0;
      p1_q    <= '0;
      p0_q    <= '0;
      pts_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      link_q  <= 1'b0;
`ifdef SCORE_RX_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      fs_q    <= fs_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      p0_q    <= p0_d;
      pts_q   <= pts_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      link_q  <= link_d;
`ifdef SCORE_RX_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign chk = p2_q ^ p1_q ^ p0_q;

  always_comb begin
    fs_d    = fs_q;
    p2_d    = p2_q;
    p1_d    = p1_q;
    p0_d    = p0_q;
    pts_d   = pts_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    link_d  = link_q;
`ifdef SCORE_RX_TIMEOUT_EN
    to_hit = (fs_q != F_HDR) && byte_idle && (to_q == TO_M1);
    to_d   = to_q;
    if (byte_ok || fs_q == F_HDR || to_hit) to_d = '0;
    else if (byte_idle) to_d = to_q + 1'b1;
`endif
    // byte_err wins, so a coincident timeout yields one pulse
    if (byte_err) begin
      err_d = 1'b1;
      fs_d  = F_HDR;
    end else if (byte_ok) begin
      unique case (fs_q)
        F_HDR: if (bdata == SCORE_HDR) fs_d = F_P2;
        F_P2: begin
          p2_d = bdata;
          fs_d = F_P1;
        end
        F_P1: begin
          p1_d = bdata;
          fs_d = F_P0;
        end
        F_P0: begin
          p0_d = bdata;
          fs_d = F_CHK;
        end
        F_CHK: begin
          fs_d = F_HDR;
          if (bdata == chk && bcd_ok({p2_q, p1_q, p0_q})) begin
            pts_d   = {p2_q, p1_q, p0_q};
            valid_d = 1'b1;
            link_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: fs_d = F_HDR;
      endcase
    end
`ifdef SCORE_RX_TIMEOUT_EN
    else if (to_hit) begin
      err_d = 1'b1;
      fs_d  = F_HDR;
    end
`endif
  end

  assign bus.points_out   = pts_q;
  assign bus.points_valid = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.link_up      = link_q;

endmodule

// File: tb/tb_score_frame_rx.sv
// Directed bench for score_frame_rx at a scaled-down 16 clocks per bit.
// Timeout case runs only with SCORE_RX_TIMEOUT_EN defined.
module tb_score_frame_rx;
  import score_frame_rx_pkg::*;

  localparam int HZ  = 1600;
  localparam int BD  = 100;
  localparam int CPB = 16;

  typedef struct {
    logic [4:0][7:0] frm;
    logic [23:0]     pts;
    int              dv;
    int              de;
  } vec_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;
  int   nerr   = 0;
  int   v0, e0;
  vec_t tbl[6];

  score_frame_rx_if bus();

  score_frame_rx #(
    .CLK_HZ(HZ),
    .BAUD  (BD)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (!rst) begin
      if (bus.points_valid) nvalid++;
      if (bus.frame_err) nerr++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    bus.rx = 1'b0;
    repeat (CPB) @(posedge pclk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(posedge pclk);
    end
    bus.rx = !bad_stop;
    repeat (CPB) @(posedge pclk);
    if (bad_stop) begin
      bus.rx = 1'b1;
      repeat (CPB) @(posedge pclk);
    end
  endtask

  task automatic send_frame(input logic [4:0][7:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[i], 1'b0);
  endtask

  task automatic settle();
    repeat (4) @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic mark();
    v0 = nvalid;
    e0 = nerr;
  endtask

  task automatic expect_out(input string name, input logic [23:0] pts,
                            input int dv, input int de);
    chk({name, "_pts"}, {8'h0, bus.points_out}, {8'h0, pts});
    chk({name, "_valid"}, nvalid - v0, dv);
    chk({name, "_err"}, nerr - e0, de);
    chk({name, "_link"}, {31'h0, bus.link_up}, 32'h1);
  endtask

  initial begin
    tbl[0] = '{{8'h67, 8'h45, 8'h23, 8'h01, 8'hA5}, 24'h012345, 1, 0};
    tbl[1] = '{{8'h00, 8'h45, 8'h23, 8'h01, 8'hA5}, 24'h012345, 0, 1};
    tbl[2] = '{{8'h0A, 8'h00, 8'h00, 8'h0A, 8'hA5}, 24'h012345, 0, 1};
    tbl[3] = '{{8'h99, 8'h99, 8'h99, 8'h99, 8'hA5}, 24'h999999, 1, 0};
    tbl[4] = '{{8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5}, 24'h999999, 0, 1};
    tbl[5] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 24'h000000, 1, 0};

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pts", {8'h0, bus.points_out}, 32'h0);
    chk("rst_valid", {31'h0, bus.points_valid}, 32'h0);
    chk("rst_err", {31'h0, bus.frame_err}, 32'h0);
    chk("rst_link", {31'h0, bus.link_up}, 32'h0);
    rst = 1'b0;
    repeat (CPB) @(posedge pclk);

    for (int i = 0; i < 6; i++) begin
      mark();
      send_frame(tbl[i].frm);
      settle();
      expect_out($sformatf("vec%0d", i), tbl[i].pts, tbl[i].dv, tbl[i].de);
    end

    // short low glitch is a false start
    mark();
    @(posedge pclk);
    bus.rx = 1'b0;
    repeat (4) @(posedge pclk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge pclk);
    send_frame({8'h70, 8'h56, 8'h34, 8'h12, 8'hA5});
    settle();
    expect_out("glitch", 24'h123456, 1, 0);

    // bad stop bit mid-frame
    mark();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h12, 1'b1);
    send_frame({8'h07, 8'h07, 8'h00, 8'h00, 8'hA5});
    settle();
    expect_out("badstop", 24'h000007, 1, 1);

    // junk before header is dropped silently
    mark();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_frame({8'h00, 8'h00, 8'h00, 8'h00, 8'hA5});
    settle();
    expect_out("junk", 24'h000000, 1, 0);

    // back-to-back frames, no idle gap
    mark();
    send_frame({8'h70, 8'h56, 8'h34, 8'h12, 8'hA5});
    send_frame({8'hBA, 8'h54, 8'h76, 8'h98, 8'hA5});
    settle();
    expect_out("b2b", 24'h987654, 2, 0);

    // reset in the middle of the P1 byte
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.rx = 1'b0;
    repeat (CPB) @(posedge pclk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge pclk);
    #1 rst = 1'b1;
    @(negedge pclk);
    chk("midrst_pts", {8'h0, bus.points_out}, 32'h0);
    chk("midrst_valid", {31'h0, bus.points_valid}, 32'h0);
    chk("midrst_err", {31'h0, bus.frame_err}, 32'h0);
    chk("midrst_link", {31'h0, bus.link_up}, 32'h0);
    repeat (2 * CPB) @(posedge pclk);
    rst = 1'b0;
    repeat (CPB) @(posedge pclk);
    mark();
    send_frame({8'h01, 8'h00, 8'h01, 8'h00, 8'hA5});
    settle();
    expect_out("postrst", 24'h000100, 1, 0);

`ifdef SCORE_RX_TIMEOUT_EN
    mark();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (31 * CPB) @(posedge pclk);
    @(negedge pclk);
    chk("timeout_err", nerr - e0, 1);
    mark();
    send_frame({8'h02, 8'h00, 8'h02, 8'h00, 8'hA5});
    settle();
    expect_out("after_to", 24'h000200, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
